cordic_pipe: RTL

- Parametrised, fully pipelined CORDIC engine supporting both rotation mode and vectoring mode, selectable per sample.
- Accepts one sample per clock through a valid/ready handshake, with a global stall under output backpressure.
- Sits in the DSP datapath as the shared trigonometry unit:
  - rotation mode: NCO/mixer rotation;
  - vectoring mode: magnitude/phase extraction.

---
 rtl/cordic_pipe.sv | 101 ++++++++++
 1 files changed

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined rotation/vectoring CORDIC, one sample per clock, global stall on backpressure
// Ports: clock/reset_n (async active-low); in_valid/in_ready/in_mode/angle/Xin/Yin input handshake;
//        out_valid/out_ready/out_mode/Xout/Yout/Zout output handshake (X/Y carry the ~1.6468 CORDIC gain)
module cordic_pipe #(
  parameter int XY_SZ = 16,
  parameter int STG   = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [31:0]             angle,
  input  logic signed [XY_SZ-1:0] Xin,
  input  logic signed [XY_SZ-1:0] Yin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic signed [XY_SZ+1:0] Xout,
  output logic signed [XY_SZ+1:0] Yout,
  output logic [31:0]             Zout
);
  localparam int W = XY_SZ + 2;
  localparam logic [31:0] ATAN [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };
  logic signed [W-1:0] x_q [0:STG];
  logic signed [W-1:0] x_d [0:STG];
  logic signed [W-1:0] y_q [0:STG];
  logic signed [W-1:0] y_d [0:STG];
  logic [31:0]         z_q [0:STG];
  logic [31:0]         z_d [0:STG];
  logic                m_q [0:STG];
  logic                m_d [0:STG];
  logic                v_q [0:STG];
  logic                v_d [0:STG];
  logic signed [W-1:0] xe, ye;
  logic [1:0]          quad;
  logic                stall, dir, xn, yn;
  assign out_valid = v_q[STG];
  assign out_mode  = m_q[STG];
  assign Xout      = x_q[STG];
  assign Yout      = y_q[STG];
  assign Zout      = z_q[STG];
  always_comb begin
    stall    = out_valid & ~out_ready;
    in_ready = ~stall;
    // widen before negating so the most negative input negates cleanly
    xe       = W'(Xin);
    ye       = W'(Yin);
    quad     = angle[31:30];
    xn       = Xin[XY_SZ-1];
    yn       = Yin[XY_SZ-1];
    dir      = 1'b0;
    // stage 0: fold the input into the +/-90 degree convergence range
    x_d[0]   = in_mode ? (xn ? (yn ? -ye : ye) : xe)
                       : (quad == 2'b01 ? -ye : quad == 2'b10 ? ye : xe);
    y_d[0]   = in_mode ? (xn ? (yn ? xe : -xe) : ye)
                       : (quad == 2'b01 ? xe : quad == 2'b10 ? -xe : ye);
    z_d[0]   = in_mode ? (xn ? (yn ? 32'hC000_0000 : 32'h4000_0000) : 32'h0)
                       : (quad == 2'b01 ? {2'b00, angle[29:0]} :
                          quad == 2'b10 ? {2'b11, angle[29:0]} : angle);
    m_d[0]   = in_mode;
    v_d[0]   = in_valid;
    for (int i = 0; i < STG; i++) begin
      // rotation drives z to zero, vectoring drives y to zero
      dir        = m_q[i] ? y_q[i][W-1] : ~z_q[i][31];
      x_d[i+1]   = dir ? x_q[i] - (y_q[i] >>> i) : x_q[i] + (y_q[i] >>> i);
      y_d[i+1]   = dir ? y_q[i] + (x_q[i] >>> i) : y_q[i] - (x_q[i] >>> i);
      z_d[i+1]   = dir ? z_q[i] - ATAN[i] : z_q[i] + ATAN[i];
      m_d[i+1]   = m_q[i];
      v_d[i+1]   = v_q[i];
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= STG; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
        m_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (!stall) begin
      for (int k = 0; k <= STG; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        z_q[k] <= z_d[k];
        m_q[k] <= m_d[k];
        v_q[k] <= v_d[k];
      end
    end
  end
endmodule
